// File: rtl/ccff_loader_pkg.sv
// Shared types and width helpers for the configuration-chain loader.
package ccff_loader_pkg;

  localparam int unsigned ERR_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned chain_len);
    return $clog2(chain_len + 1);
  endfunction

  function automatic int unsigned wcnt_w(input int unsigned word_w);
    return $clog2(word_w + 1);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// One-word buffer that turns stream words into an MSB-first bit stream.
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_busy,
  input  logic              i_clear,
  input  logic              i_flush,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_shift,
  output logic              o_head
);

  localparam int unsigned WCNT_W = wcnt_w(WORD_W);

  logic [WORD_W-1:0] r_sreg;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_full;
  logic              w_last_bit;
  logic              w_accept;

  // Refill during the last bit of a word keeps the stream gapless; never
  // refill on a phase-ending bit, since that word belongs to the next pass.
  assign o_shift    = i_busy & r_full;
  assign w_last_bit = o_shift & (r_wcnt == WCNT_W'(1));
  assign o_ready    = i_busy & ~i_flush & (~r_full | w_last_bit);
  assign w_accept   = i_valid & o_ready;
  assign o_head     = o_shift & r_sreg[WORD_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sreg <= '0;
      r_wcnt <= '0;
      r_full <= 1'b0;
    end else if (i_clear || i_flush) begin
      r_sreg <= '0;
      r_wcnt <= '0;
      r_full <= 1'b0;
    end else if (w_accept) begin
      r_sreg <= i_data;
      r_wcnt <= WCNT_W'(WORD_W);
      r_full <= 1'b1;
    end else if (o_shift) begin
      r_sreg <= r_sreg << 1;
      r_wcnt <= r_wcnt - WCNT_W'(1);
      if (w_last_bit) r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Shifts a streamed bitstream into the fabric config chain, optionally re-streaming it to verify the tail.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned ERR_W     = ERR_W_DEF
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned CNT_W = cnt_w(CHAIN_LEN);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_verify;
  logic             r_error;
  logic [ERR_W-1:0] r_err_count;
  logic             w_start_ok;
  logic             w_phase_end;
  logic             w_mismatch;

  assign busy        = (r_state == ST_LOAD) | (r_state == ST_VERIFY);
  assign done        = (r_state == ST_DONE);
  assign error       = r_error;
  assign err_count   = r_err_count;
  assign w_start_ok  = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_phase_end = ccff_shift_en & (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign w_mismatch  = (r_state == ST_VERIFY) & ccff_shift_en & (ccff_tail != ccff_head);

  ccff_word_serializer #(
    .WORD_W(WORD_W)
  ) u_ser (
    .clk     (prog_clk),
    .rst     (prog_reset),
    .i_busy  (busy),
    .i_clear (w_start_ok),
    .i_flush (w_phase_end),
    .i_data  (s_data),
    .i_valid (s_valid),
    .o_ready (s_ready),
    .o_shift (ccff_shift_en),
    .o_head  (ccff_head)
  );

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_LOAD;
      ST_LOAD:          if (w_phase_end) w_state_nxt = r_verify ? ST_VERIFY : ST_DONE;
      ST_VERIFY:        if (w_phase_end) w_state_nxt = ST_DONE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  // Session bookkeeping: chain position, latched verify mode and mismatch tally.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      r_bit_cnt   <= '0;
      r_verify    <= 1'b0;
      r_error     <= 1'b0;
      r_err_count <= '0;
    end else if (w_start_ok) begin
      r_bit_cnt   <= '0;
      r_verify    <= verify_en;
      r_error     <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_phase_end)        r_bit_cnt <= '0;
      else if (ccff_shift_en) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      if (w_mismatch) begin
        r_error <= 1'b1;
        if (r_err_count != {ERR_W{1'b1}}) r_err_count <= r_err_count + ERR_W'(1);
      end
    end
  end

endmodule
